// File: rtl/dbg_cmd_client_if.sv
// String-buffer link between the UART debug top (master) and the fabric-side
// command client (slave): one received-line handshake and one send handshake.
interface dbg_cmd_client_if #(
  parameter int SIZE = 32
);
  logic [SIZE*8-1:0] line_i;
  logic              line_i_trigger;
  logic              line_i_ready;
  logic [SIZE*8-1:0] str_o;
  logic              str_o_trigger;
  logic              str_o_ready;

  modport master (
    output line_i, line_i_trigger, str_o_ready,
    input  line_i_ready, str_o, str_o_trigger
  );

  modport slave (
    input  line_i, line_i_trigger, str_o_ready,
    output line_i_ready, str_o, str_o_trigger
  );
endinterface

// File: rtl/dbg_cmd_client.sv
// Fabric-side debug command processor. Takes one text line from the UART
// top, parses "Rn" (peek) or "Wn HH" (poke), runs it against a small byte
// register file and hands back a four-character ASCII reply.
module dbg_cmd_client #(
  parameter int SIZE = 32,
  parameter int REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  dbg_cmd_client_if.slave   bus,
  output logic [REGS*8-1:0] regs_o,
  output logic [15:0]       cmd_count,
  output logic [7:0]        err_count
);

  if (SIZE < 8) begin : g_size_chk
    $error("dbg_cmd_client: SIZE must be at least 8");
  end
  if (REGS < 1 || REGS > 16) begin : g_regs_chk
    $error("dbg_cmd_client: REGS must be in 1..16");
  end

  typedef enum logic [2:0] {IDLE, WAIT_LINE, PARSE, EXEC, LOAD, SEND} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_ERR} kind_t;

  // {valid, value} for one ASCII hex digit, either case.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  // Uppercase ASCII for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state;
  logic        trig_d;
  logic [47:0] line_q;
  kind_t       kind_q;
  logic [3:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_q;

  // Only the first six characters can form a legal command.
  logic unused_line_tail;
  assign unused_line_tail = ^bus.line_i[SIZE*8-1:48];

  logic accept;
  assign accept = (state == WAIT_LINE) && bus.line_i_trigger && !trig_d;

  logic [7:0] b0, b1, b2, b3, b4, b5;
  assign b0 = line_q[7:0];
  assign b1 = line_q[15:8];
  assign b2 = line_q[23:16];
  assign b3 = line_q[31:24];
  assign b4 = line_q[39:32];
  assign b5 = line_q[47:40];

  logic [4:0] h1, h3, h4;
  assign h1 = hex_decode(b1);
  assign h3 = hex_decode(b3);
  assign h4 = hex_decode(b4);

  logic addr_ok, rd_ok, wr_ok;
  assign addr_ok = h1[4] && (32'(h1[3:0]) < REGS);
  assign rd_ok   = (b0 == 8'h52 || b0 == 8'h72) && addr_ok && (b2 == 8'h0D);
  assign wr_ok   = (b0 == 8'h57 || b0 == 8'h77) && addr_ok && (b2 == 8'h20)
                   && h3[4] && h4[4] && (b5 == 8'h0D);

  // Reply image for the command decided in PARSE; everything past byte 3 is zero.
  logic [SIZE*8-1:0] reply;
  always_comb begin
    reply = '0;
    unique case (kind_q)
      K_READ:  reply[31:0] = {8'h0A, 8'h0D, hex_char(rd_q[3:0]), hex_char(rd_q[7:4])};
      K_WRITE: reply[31:0] = 32'h0A0D_4B4F;
      default: reply[31:0] = 32'h0A0D_5245;
    endcase
  end

  // Command datapath: line capture, decode results and read snapshot.
  always_ff @(posedge clk) begin
    if (accept) line_q <= bus.line_i[47:0];
    if (state == PARSE) begin
      kind_q  <= rd_ok ? K_READ : (wr_ok ? K_WRITE : K_ERR);
      addr_q  <= h1[3:0];
      wdata_q <= {h3[3:0], h4[3:0]};
    end
    if (state == EXEC && kind_q == K_READ) rd_q <= regs_o[int'(addr_q)*8 +: 8];
  end

  // Control FSM with registered handshakes, register file and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      trig_d            <= 1'b0;
      bus.line_i_ready  <= 1'b0;
      bus.str_o         <= '0;
      bus.str_o_trigger <= 1'b0;
      regs_o            <= '0;
      cmd_count         <= 16'd0;
      err_count         <= 8'd0;
    end else begin
      trig_d <= bus.line_i_trigger;
      unique case (state)
        IDLE: begin
          bus.line_i_ready <= 1'b1;
          state            <= WAIT_LINE;
        end
        WAIT_LINE: begin
          if (accept) begin
            bus.line_i_ready <= 1'b0;
            cmd_count        <= cmd_count + 16'd1;
            state            <= PARSE;
          end
        end
        PARSE: state <= EXEC;
        EXEC: begin
          if (kind_q == K_WRITE) regs_o[int'(addr_q)*8 +: 8] <= wdata_q;
          else if (kind_q == K_ERR) err_count <= sat_inc8(err_count);
          state <= LOAD;
        end
        LOAD: begin
          bus.str_o         <= reply;
          bus.str_o_trigger <= 1'b1;
          state             <= SEND;
        end
        SEND: begin
          // Trigger must fall before the UART top goes idle or it resends.
          if (bus.str_o_ready) begin
            bus.str_o_trigger <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_cmd_client.sv
// Directed bench for dbg_cmd_client: plays the UART top side of the link.
module tb_dbg_cmd_client;
  localparam int SIZE = 32;
  localparam int REGS = 16;

  logic              clk;
  logic              rst;
  logic [REGS*8-1:0] regs_o;
  logic [15:0]       cmd_count;
  logic [7:0]        err_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  dbg_cmd_client_if #(.SIZE(SIZE)) bus ();

  dbg_cmd_client #(.SIZE(SIZE), .REGS(REGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .regs_o    (regs_o),
    .cmd_count (cmd_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SIZE*8-1:0] reply_vec(input logic [31:0] w);
    logic [SIZE*8-1:0] v;
    v = '0;
    v[31:0] = w;
    return v;
  endfunction

  function automatic logic [SIZE*8-1:0] pack_line(input string s);
    logic [SIZE*8-1:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
    v[8*s.len() +: 8]     = 8'h0D;
    v[8*(s.len()+1) +: 8] = 8'h0A;
    return v;
  endfunction

  // One full receive/reply exchange as the UART top would perform it.
  task automatic run_line(input string s, output logic [SIZE*8-1:0] rep, output bit ok);
    int n;
    ok  = 1'b1;
    rep = '0;
    @(negedge clk);
    n = 0;
    while (!bus.line_i_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.line_i_ready) ok = 1'b0;
    bus.line_i         = pack_line(s);
    bus.line_i_trigger = 1'b1;
    n = 0;
    while (!bus.str_o_trigger && n < 50) begin @(negedge clk); n++; end
    if (!bus.str_o_trigger) ok = 1'b0;
    rep = bus.str_o;
    bus.str_o_ready = 1'b1;
    @(negedge clk);
    bus.str_o_ready = 1'b0;
    n = 0;
    while (!bus.line_i_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.line_i_ready) ok = 1'b0;
    bus.line_i_trigger = 1'b0;
  endtask

  task automatic do_reset();
    bus.line_i_trigger = 1'b0;
    bus.str_o_ready    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.line_i         = '0;
    bus.line_i_trigger = 1'b0;
    bus.str_o_ready    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (bus.line_i_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.line_i_ready); else pass_cnt++;
    chk_cnt++; if (bus.str_o_trigger !== 1'b0) $display("FAIL reset_trigger got %b want 0", bus.str_o_trigger); else pass_cnt++;
    chk_cnt++; if (bus.str_o !== '0) $display("FAIL reset_str got %h want 0", bus.str_o); else pass_cnt++;
    chk_cnt++; if (regs_o !== '0) $display("FAIL reset_regs got %h want 0", regs_o); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd0) $display("FAIL reset_cmd got %0d want 0", cmd_count); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'd0) $display("FAIL reset_err got %0d want 0", err_count); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.line_i_ready !== 1'b1) $display("FAIL arm_ready got %b want 1", bus.line_i_ready); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [SIZE*8-1:0] rep;
    bit ok;
    run_line("W3 A5", rep, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL write_handshake got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (rep !== reply_vec(32'h0A0D4B4F)) $display("FAIL write_reply got %h want %h", rep, reply_vec(32'h0A0D4B4F)); else pass_cnt++;
    chk_cnt++; if (regs_o !== 128'hA5000000) $display("FAIL write_regs got %h want %h", regs_o, 128'hA5000000); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd1) $display("FAIL write_cmd got %0d want 1", cmd_count); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'd0) $display("FAIL write_err got %0d want 0", err_count); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [SIZE*8-1:0] rep;
    bit ok;
    run_line("r3", rep, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL read_handshake got %b want 1", ok); else pass_cnt++;
    chk_cnt++; if (rep !== reply_vec(32'h0A0D3541)) $display("FAIL read_reply got %h want %h", rep, reply_vec(32'h0A0D3541)); else pass_cnt++;
    chk_cnt++; if (regs_o !== 128'hA5000000) $display("FAIL read_regs got %h want %h", regs_o, 128'hA5000000); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd2) $display("FAIL read_cmd got %0d want 2", cmd_count); else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [SIZE*8-1:0] rep;
    bit ok;
    string lines [3];
    lines[0] = "X1";
    lines[1] = "";
    lines[2] = "W3 G0";
    for (int i = 0; i < 3; i++) begin
      run_line(lines[i], rep, ok);
      chk_cnt++; if (ok !== 1'b1 || rep !== reply_vec(32'h0A0D5245))
        $display("FAIL err_reply_%0d got %h ok=%b want %h", i, rep, ok, reply_vec(32'h0A0D5245)); else pass_cnt++;
    end
    chk_cnt++; if (err_count !== 8'd3) $display("FAIL err_count got %0d want 3", err_count); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd5) $display("FAIL err_cmd got %0d want 5", cmd_count); else pass_cnt++;
    chk_cnt++; if (regs_o !== 128'hA5000000) $display("FAIL err_regs got %h want %h", regs_o, 128'hA5000000); else pass_cnt++;
  endtask

  task automatic test_trigger_hold();
    logic [SIZE*8-1:0] snap;
    int n, held, rises;
    logic prev;
    @(negedge clk);
    n = 0;
    while (!bus.line_i_ready && n < 50) begin @(negedge clk); n++; end
    bus.line_i         = pack_line("R3");
    bus.line_i_trigger = 1'b1;
    held = 0;
    n = 0;
    while (!bus.str_o_trigger && n < 50) begin @(negedge clk); n++; end
    held = n;
    chk_cnt++; if (n !== 4) $display("FAIL hold_latency got %0d want 4", n); else pass_cnt++;
    snap = bus.str_o;
    chk_cnt++; if (snap !== reply_vec(32'h0A0D3541)) $display("FAIL hold_reply got %h want %h", snap, reply_vec(32'h0A0D3541)); else pass_cnt++;
    repeat (3) @(negedge clk);
    held += 3;
    chk_cnt++; if (bus.str_o_trigger !== 1'b1 || bus.str_o !== snap)
      $display("FAIL hold_stable got trig=%b str=%h want trig=1 str=%h", bus.str_o_trigger, bus.str_o, snap); else pass_cnt++;
    bus.str_o_ready = 1'b1;
    @(negedge clk);
    held++;
    bus.str_o_ready = 1'b0;
    chk_cnt++; if (bus.str_o_trigger !== 1'b0) $display("FAIL hold_trig_drop got %b want 0", bus.str_o_trigger); else pass_cnt++;
    n = 0;
    while (!bus.line_i_ready && n < 50) begin @(negedge clk); n++; held++; end
    chk_cnt++; if (bus.line_i_ready !== 1'b1 || bus.str_o_trigger !== 1'b0)
      $display("FAIL hold_rearm got ready=%b trig=%b want ready=1 trig=0", bus.line_i_ready, bus.str_o_trigger); else pass_cnt++;
    rises = 0;
    prev  = bus.str_o_trigger;
    while (held < 500) begin
      @(negedge clk);
      held++;
      if (bus.str_o_trigger && !prev) rises++;
      prev = bus.str_o_trigger;
    end
    chk_cnt++; if (rises !== 0) $display("FAIL hold_extra_replies got %0d want 0", rises); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd6) $display("FAIL hold_cmd got %0d want 6", cmd_count); else pass_cnt++;
    bus.line_i_trigger = 1'b0;
  endtask

  task automatic test_err_saturation();
    logic [SIZE*8-1:0] rep;
    bit ok;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      run_line("X1", rep, ok);
      if (ok && rep === reply_vec(32'h0A0D5245)) bad++;
    end
    chk_cnt++; if (bad !== 256) $display("FAIL sat_replies got %0d want 256", bad); else pass_cnt++;
    chk_cnt++; if (err_count !== 8'hFF) $display("FAIL sat_err_256 got %h want ff", err_count); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd256) $display("FAIL sat_cmd_256 got %0d want 256", cmd_count); else pass_cnt++;
    run_line("", rep, ok);
    chk_cnt++; if (err_count !== 8'hFF) $display("FAIL sat_err_257 got %h want ff", err_count); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd257) $display("FAIL sat_cmd_257 got %0d want 257", cmd_count); else pass_cnt++;
  endtask

  task automatic test_reset_in_send();
    logic [SIZE*8-1:0] rep;
    bit ok;
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.line_i_ready && n < 50) begin @(negedge clk); n++; end
    bus.line_i         = pack_line("W5 3C");
    bus.line_i_trigger = 1'b1;
    n = 0;
    while (!bus.str_o_trigger && n < 50) begin @(negedge clk); n++; end
    chk_cnt++; if (bus.str_o_trigger !== 1'b1) $display("FAIL rsend_reach got %b want 1", bus.str_o_trigger); else pass_cnt++;
    rst = 1'b1;
    bus.line_i_trigger = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.str_o_trigger !== 1'b0) $display("FAIL rsend_trig got %b want 0", bus.str_o_trigger); else pass_cnt++;
    chk_cnt++; if (bus.str_o !== '0) $display("FAIL rsend_str got %h want 0", bus.str_o); else pass_cnt++;
    chk_cnt++; if (regs_o !== '0) $display("FAIL rsend_regs got %h want 0", regs_o); else pass_cnt++;
    rst = 1'b0;
    run_line("W5 3C", rep, ok);
    chk_cnt++; if (ok !== 1'b1 || rep !== reply_vec(32'h0A0D4B4F))
      $display("FAIL rsend_next_reply got %h ok=%b want %h", rep, ok, reply_vec(32'h0A0D4B4F)); else pass_cnt++;
    chk_cnt++; if (regs_o !== 128'h3C0000000000) $display("FAIL rsend_next_regs got %h want %h", regs_o, 128'h3C0000000000); else pass_cnt++;
    chk_cnt++; if (cmd_count !== 16'd1) $display("FAIL rsend_next_cmd got %0d want 1", cmd_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_trigger_hold();
    test_err_saturation();
    test_reset_in_send();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
